// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Holds size codes, FSM state constants, the latched-request record and
// the request legality check used by the responder FSM.
package dm_pkg;

    // Access size encodings as driven by the core on the size port.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Largest supported wait-state count; the counter is sized for it.
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    // Request payload captured in IDLE and replayed through WAIT/RESP.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata;
    } dm_req_t;

    // A request is legal when it targets the implemented address range
    // and is naturally aligned for its size. Size 11 is never legal.
    function automatic logic req_legal(
        input logic [31:0] addr,
        input logic [1:0]  size,
        input int          addr_w
    );
        logic in_range;
        logic aligned;
        in_range = ((addr >> (addr_w + 2)) == 32'd0);
        case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            SZ_WORD: aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return in_range && aligned;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for the data-memory responder.
// Store path merges right-justified write data into the addressed lanes of
// the old word; load path extracts the addressed lanes and extends them.
// Lanes are little-endian: offset 0 is bits [7:0], offset 3 is [31:24].
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign,
    input  logic [31:0] rd_word,
    output logic [31:0] merged,
    output logic [31:0] ld_result
);

    logic [31:0] placed;
    logic [3:0]  lane_en;
    logic [31:0] shifted;

    // Replicate the store data so every candidate lane sees the right bits.
    always_comb begin
        case (size)
            SZ_BYTE: placed = {4{wdata[7:0]}};
            SZ_HALF: placed = {2{wdata[15:0]}};
            default: placed = wdata;
        endcase
    end

    // Per-lane write enables and merge with the old word contents.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_en[gi] = (size == SZ_WORD)
                          || ((size == SZ_HALF) && (offset[1] == LANE[1]))
                          || ((size == SZ_BYTE) && (offset == LANE));
        assign merged[8*gi +: 8] = lane_en[gi] ? placed[8*gi +: 8]
                                               : old_word[8*gi +: 8];
    end

    // Bring the addressed lane down to bit 0 for extraction.
    assign shifted = rd_word >> {offset, 3'b000};

    // Extend the extracted byte/halfword; words pass through untouched.
    always_comb begin
        case (size)
            SZ_BYTE: ld_result = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_result = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: ld_result = rd_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the core's load/store port.
// Accepts one request at a time, inserts WAIT_CYC wait states, then pulses
// ack for one cycle with load data or an error flag. Stores commit on the
// edge entering RESP as a read-modify-write of the addressed word.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    dm_req_t           lat_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;

    dm_req_t           in_req;
    dm_req_t           act;
    logic              act_legal;
    logic              enter_resp;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic [31:0]       ld_result;

    logic [31:0]       mem [DEPTH];

    assign in_req = '{we: we, addr: addr, size: size, sign: sign, wdata: wdata};

    // In IDLE the live inputs are the request being accepted; afterwards
    // only the latched copy matters, so later bus changes are ignored.
    assign act       = (state_reg == ST_IDLE) ? in_req : lat_reg;
    assign act_legal = req_legal(act.addr, act.size, ADDR_W);
    assign word_idx  = act.addr[ADDR_W+1:2];
    assign rd_word   = mem[word_idx];

    // Next-state and wait-counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (!act_legal || (WAIT_CYC == 0)) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The memory access (read for loads, RMW for stores) happens on the
    // single edge that moves the FSM into RESP.
    assign enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);

    dm_lane u_lane (
        .old_word  (rd_word),
        .wdata     (act.wdata),
        .size      (act.size),
        .offset    (act.addr[1:0]),
        .sign      (act.sign),
        .rd_word   (rd_word),
        .merged    (merged),
        .ld_result (ld_result)
    );

    // Memory array write port; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && act_legal && act.we) begin
            mem[word_idx] <= merged;
        end
    end

    // FSM, counter, request latch and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            lat_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if ((state_reg == ST_IDLE) && req) begin
                lat_reg <= in_req;
            end
            if (enter_resp) begin
                err_reg   <= ~act_legal;
                rdata_reg <= (act_legal && !act.we) ? ld_result : 32'd0;
            end else if (state_reg == ST_RESP) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign ack   = (state_reg == ST_RESP);
    assign rdata = rdata_reg;
    assign err   = err_reg;

endmodule
